// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter shared types and constants.
// Imported by the arbiter top.
package ram_arbiter_pkg;

  localparam int WORD_W = 32;

  localparam logic RAM_WE_ON  = 1'b0;
  localparam logic RAM_WE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_t;

  function automatic logic is_ram_state(
    input state_t s
  );
    return (s == RD_LO) || (s == RD_HI) ||
           (s == WR_LO) || (s == WR_HI);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Fetch/Memory word arbiter onto a 16-bit SRAM.
// Each word is two halfword RAM cycles on the 2x clock.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int RAM_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_mc_en,
  input  logic [ADDR_W-1:0] if_mc_addr,
  output logic [WORD_W-1:0] mc_if_data,
  output logic              mc_if_valid,
  input  logic              mem_mc_en,
  input  logic              mem_mc_rw,
  input  logic [ADDR_W-1:0] mem_mc_addr,
  input  logic [WORD_W-1:0] mem_mc_wdata,
  output logic [WORD_W-1:0] mc_mem_rdata,
  output logic              mc_mem_valid,
  output logic [ADDR_W-1:0] mc_ram_addr,
  output logic              mc_ram_wre,
  output logic [RAM_W-1:0]  mc_ram_dout,
  output logic              mc_ram_doe,
  input  logic [RAM_W-1:0]  mc_ram_din
);

  state_t state;
  state_t state_nx;

  req_t              req_q;
  logic [ADDR_W-2:0] wa_q;
  logic [WORD_W-1:0] wd_q;
  logic [RAM_W-1:0]  lo_q;

  logic              accept;
  logic [ADDR_W-2:0] sel_wa;
  logic [WORD_W-1:0] sel_wd;

  logic [ADDR_W-1:0] addr_d;
  logic [RAM_W-1:0]  dout_d;
  logic              wre_d;
  logic              doe_d;
  logic              done_d;

  assign accept = (state == IDLE) &&
                  (mem_mc_en || if_mc_en);

  // In IDLE the first RAM cycle is built from
  // the live request; afterwards from latches.
  always_comb begin
    sel_wa = wa_q;
    sel_wd = wd_q;
    if (state == IDLE) begin
      sel_wd = mem_mc_wdata;
      if (mem_mc_en)
        sel_wa = mem_mc_addr[ADDR_W-1:1];
      else
        sel_wa = if_mc_addr[ADDR_W-1:1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (mem_mc_en)
          state_nx = mem_mc_rw ? WR_LO : RD_LO;
        else if (if_mc_en)
          state_nx = RD_LO;
      end
      RD_LO:   state_nx = RD_HI;
      RD_HI:   state_nx = DONE;
      WR_LO:   state_nx = WR_HI;
      WR_HI:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin values for the upcoming state; registered
  // so no request input reaches the SRAM pins.
  always_comb begin
    addr_d = mc_ram_addr;
    dout_d = mc_ram_dout;
    wre_d  = RAM_WE_OFF;
    doe_d  = 1'b0;
    done_d = (state_nx == DONE);
    unique case (state_nx)
      RD_LO: addr_d = {sel_wa, 1'b0};
      RD_HI: addr_d = {sel_wa, 1'b1};
      WR_LO: begin
        addr_d = {sel_wa, 1'b0};
        dout_d = sel_wd[RAM_W-1:0];
        wre_d  = RAM_WE_ON;
        doe_d  = 1'b1;
      end
      WR_HI: begin
        addr_d = {sel_wa, 1'b1};
        dout_d = sel_wd[WORD_W-1:RAM_W];
        wre_d  = RAM_WE_ON;
        doe_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mc_ram_addr <= '0;
      mc_ram_dout <= '0;
      mc_ram_wre  <= RAM_WE_OFF;
      mc_ram_doe  <= 1'b0;
    end else begin
      mc_ram_addr <= addr_d;
      mc_ram_dout <= dout_d;
      mc_ram_wre  <= wre_d;
      mc_ram_doe  <= doe_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q <= REQ_IF;
      wa_q  <= '0;
      wd_q  <= '0;
    end else if (accept) begin
      req_q <= mem_mc_en ? REQ_MEM : REQ_IF;
      wa_q  <= sel_wa;
      wd_q  <= mem_mc_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      lo_q <= '0;
    else if (state == RD_LO)
      lo_q <= mc_ram_din;
  end

  // Data and valid land together at DONE entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      mc_if_data   <= '0;
      mc_mem_rdata <= '0;
      mc_if_valid  <= 1'b0;
      mc_mem_valid <= 1'b0;
    end else begin
      mc_if_valid  <= done_d && (req_q == REQ_IF);
      mc_mem_valid <= done_d && (req_q == REQ_MEM);
      if (state == RD_HI) begin
        if (req_q == REQ_IF)
          mc_if_data <= {mc_ram_din, lo_q};
        else
          mc_mem_rdata <= {mc_ram_din, lo_q};
      end
    end
  end

  logic unused_ok;
  assign unused_ok = is_ram_state(state) &
                     if_mc_addr[0] & mem_mc_addr[0];

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter.
// Directed table plus multi-cycle corner sequences.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_mc_en;
  logic [17:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        mc_if_valid;
  logic        mem_mc_en;
  logic        mem_mc_rw;
  logic [17:0] mem_mc_addr;
  logic [31:0] mem_mc_wdata;
  logic [31:0] mc_mem_rdata;
  logic        mc_mem_valid;
  logic [17:0] mc_ram_addr;
  logic        mc_ram_wre;
  logic [15:0] mc_ram_dout;
  logic        mc_ram_doe;
  logic [15:0] mc_ram_din;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(18), .RAM_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_mc_en     (if_mc_en),
    .if_mc_addr   (if_mc_addr),
    .mc_if_data   (mc_if_data),
    .mc_if_valid  (mc_if_valid),
    .mem_mc_en    (mem_mc_en),
    .mem_mc_rw    (mem_mc_rw),
    .mem_mc_addr  (mem_mc_addr),
    .mem_mc_wdata (mem_mc_wdata),
    .mc_mem_rdata (mc_mem_rdata),
    .mc_mem_valid (mc_mem_valid),
    .mc_ram_addr  (mc_ram_addr),
    .mc_ram_wre   (mc_ram_wre),
    .mc_ram_dout  (mc_ram_dout),
    .mc_ram_doe   (mc_ram_doe),
    .mc_ram_din   (mc_ram_din)
  );

  // SRAM model: async read, write on edge
  logic [15:0] ram [0:262143];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clock) begin
    if (pl_en)
      ram[pl_addr] <= pl_data;
    else if (!mc_ram_wre && mc_ram_doe)
      ram[mc_ram_addr] <= mc_ram_dout;
  end

  assign mc_ram_din = ram[mc_ram_addr];

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_if;
  logic [31:0] exp_mem;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (mc_if_valid && mc_mem_valid) begin
        errors++;
        $display("FAIL both_valid: got 1 expected 0");
      end
    end
  end

  typedef struct {
    string       nm;
    bit          mem;
    bit          rw;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic preload(
    input logic [17:0] a,
    input logic [15:0] d
  );
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic do_access(input vec_t v);
    logic [16:0] wa;
    wa = v.addr[17:1];
    if (v.mem) begin
      mem_mc_en    = 1'b1;
      mem_mc_rw    = v.rw;
      mem_mc_addr  = v.addr;
      mem_mc_wdata = v.wdata;
    end else begin
      if_mc_en   = 1'b1;
      if_mc_addr = v.addr;
    end
    tick();
    if_mc_en     = 1'b0;
    mem_mc_en    = 1'b0;
    mem_mc_rw    = ~v.rw;
    mem_mc_addr  = 18'h2AAAA;
    mem_mc_wdata = 32'h0BAD0BAD;
    if_mc_addr   = 18'h15555;
    chk({v.nm, "_lo_addr"}, 32'(mc_ram_addr),
        32'({wa, 1'b0}));
    chk({v.nm, "_lo_wre"}, 32'(mc_ram_wre),
        32'(!v.rw));
    chk({v.nm, "_lo_doe"}, 32'(mc_ram_doe),
        32'(v.rw));
    if (v.rw)
      chk({v.nm, "_lo_dout"}, 32'(mc_ram_dout),
          32'(v.wdata[15:0]));
    tick();
    chk({v.nm, "_hi_addr"}, 32'(mc_ram_addr),
        32'({wa, 1'b1}));
    chk({v.nm, "_hi_wre"}, 32'(mc_ram_wre),
        32'(!v.rw));
    if (v.rw)
      chk({v.nm, "_hi_dout"}, 32'(mc_ram_dout),
          32'(v.wdata[31:16]));
    tick();
    if (!v.rw) begin
      if (v.mem) exp_mem = v.exp;
      else       exp_if  = v.exp;
    end
    chk({v.nm, "_if_valid"}, 32'(mc_if_valid),
        32'(!v.mem));
    chk({v.nm, "_mem_valid"}, 32'(mc_mem_valid),
        32'(v.mem));
    chk({v.nm, "_if_data"}, mc_if_data, exp_if);
    chk({v.nm, "_mem_data"}, mc_mem_rdata, exp_mem);
    chk({v.nm, "_done_wre"}, 32'(mc_ram_wre), 32'd1);
    chk({v.nm, "_done_doe"}, 32'(mc_ram_doe), 32'd0);
    tick();
    chk({v.nm, "_valid_drop"},
        32'({mc_if_valid, mc_mem_valid}), 32'd0);
    if (v.rw) begin
      chk({v.nm, "_ram_lo"}, 32'(ram[{wa, 1'b0}]),
          32'(v.wdata[15:0]));
      chk({v.nm, "_ram_hi"}, 32'(ram[{wa, 1'b1}]),
          32'(v.wdata[31:16]));
    end
  endtask

  initial begin
    int n_if;
    int n_mem;
    int p1;
    int p2;
    int pulses;

    reset        = 1'b1;
    if_mc_en     = 1'b0;
    if_mc_addr   = '0;
    mem_mc_en    = 1'b0;
    mem_mc_rw    = 1'b0;
    mem_mc_addr  = '0;
    mem_mc_wdata = '0;
    pl_en        = 1'b0;
    pl_addr      = '0;
    pl_data      = '0;
    exp_if       = '0;
    exp_mem      = '0;

    tbl[0] = '{"if_rd_odd", 1'b0, 1'b0, 18'h00101,
               32'h0, 32'h12345678};
    tbl[1] = '{"if_rd_even", 1'b0, 1'b0, 18'h00100,
               32'h0, 32'h12345678};
    tbl[2] = '{"mem_wr_top", 1'b1, 1'b1, 18'h3FFFE,
               32'hDEADBEEF, 32'h0};
    tbl[3] = '{"mem_rd_top", 1'b1, 1'b0, 18'h3FFFF,
               32'h0, 32'hDEADBEEF};
    tbl[4] = '{"mem_rd_10", 1'b1, 1'b0, 18'h00010,
               32'h0, 32'hF0F00F0F};
    tbl[5] = '{"if_rd_0", 1'b0, 1'b0, 18'h00000,
               32'h0, 32'h5555AAAA};
    tbl[6] = '{"mem_wr_200", 1'b1, 1'b1, 18'h00200,
               32'hCAFEF00D, 32'h0};
    tbl[7] = '{"if_rd_201", 1'b0, 1'b0, 18'h00201,
               32'h0, 32'hCAFEF00D};

    tick();
    preload(18'h00100, 16'h5678);
    preload(18'h00101, 16'h1234);
    preload(18'h00000, 16'hAAAA);
    preload(18'h00001, 16'h5555);
    preload(18'h00010, 16'h0F0F);
    preload(18'h00011, 16'hF0F0);

    chk("rst_if_data", mc_if_data, 32'h0);
    chk("rst_mem_data", mc_mem_rdata, 32'h0);
    chk("rst_valids",
        32'({mc_if_valid, mc_mem_valid}), 32'd0);
    chk("rst_addr", 32'(mc_ram_addr), 32'h0);
    chk("rst_dout", 32'(mc_ram_dout), 32'h0);
    chk("rst_wre", 32'(mc_ram_wre), 32'd1);
    chk("rst_doe", 32'(mc_ram_doe), 32'd0);
    reset = 1'b0;
    tick();

    // reset landing in the middle of a write
    mem_mc_en    = 1'b1;
    mem_mc_rw    = 1'b1;
    mem_mc_addr  = 18'h00040;
    mem_mc_wdata = 32'h11112222;
    tick();
    mem_mc_en = 1'b0;
    chk("midwr_wre", 32'(mc_ram_wre), 32'd0);
    chk("midwr_doe", 32'(mc_ram_doe), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_wre", 32'(mc_ram_wre), 32'd1);
    chk("abort_doe", 32'(mc_ram_doe), 32'd0);
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mc_if_valid || mc_mem_valid)
        pulses++;
      chk("abort_idle_wre", 32'(mc_ram_wre), 32'd1);
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_if_data", mc_if_data, 32'h0);
    chk("abort_mem_data", mc_mem_rdata, 32'h0);
    chk("abort_half_lo", 32'(ram[18'h00040]),
        32'h2222);

    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i]);
      tick();
    end

    // hold: address change with en low
    mem_mc_addr = 18'h00100;
    if_mc_addr  = 18'h00010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_mem_data", mc_mem_rdata, exp_mem);
      chk("hold_if_data", mc_if_data, exp_if);
      chk("hold_wre", 32'(mc_ram_wre), 32'd1);
      chk("hold_doe", 32'(mc_ram_doe), 32'd0);
    end

    // contention: both raised in the same cycle
    n_if        = 0;
    n_mem       = 0;
    if_mc_en    = 1'b1;
    if_mc_addr  = 18'h00000;
    mem_mc_en   = 1'b1;
    mem_mc_rw   = 1'b0;
    mem_mc_addr = 18'h00010;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (mc_mem_valid) begin
        if (n_mem == 0) n_mem = n;
        mem_mc_en = 1'b0;
        chk("cont_mem_data", mc_mem_rdata,
            32'hF0F00F0F);
      end
      if (mc_if_valid) begin
        if (n_if == 0) n_if = n;
        if_mc_en = 1'b0;
        chk("cont_if_data", mc_if_data,
            32'h5555AAAA);
      end
    end
    if_mc_en  = 1'b0;
    mem_mc_en = 1'b0;
    chk("cont_mem_lat", 32'(n_mem), 32'd3);
    chk("cont_if_lat", 32'(n_if), 32'd7);
    tick();

    // back-to-back with en held high
    p1          = 0;
    p2          = 0;
    mem_mc_en   = 1'b1;
    mem_mc_rw   = 1'b0;
    mem_mc_addr = 18'h00101;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (mc_mem_valid) begin
        chk("b2b_data", mc_mem_rdata, 32'h12345678);
        if (p1 == 0) p1 = n;
        else if (p2 == 0) begin
          p2        = n;
          mem_mc_en = 1'b0;
        end
      end
    end
    mem_mc_en = 1'b0;
    chk("b2b_first", 32'(p1), 32'd3);
    chk("b2b_second", 32'(p2), 32'd7);
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shared-SRAM port for the pipelined MIPS core. It sits directly below the Fetch and Memory stages and arbitrates their 32-bit word requests onto the single 16-bit external SRAM. Each word access is split into two halfword RAM cycles. The block runs on the fast board clock, which is 2x the pipeline clock, so a complete word access fits inside the requesting stage's slow cycle window.

## Interface
Parameters:
- ADDR_W, 18: SRAM halfword address width.
- RAM_W, 16: SRAM data width. Words are 2*RAM_W = 32 bits.

Ports (clock and reset first):
- clock  in  1  fast board clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- if_mc_en  in  1  Fetch read request, level.
- if_mc_addr  in  18  Fetch halfword address; bit 0 ignored.
- mc_if_data  out  32  last instruction word read for Fetch.
- mc_if_valid  out  1  one-cycle pulse when mc_if_data is updated.
- mem_mc_en  in  1  Memory-stage request, level.
- mem_mc_rw  in  1  1 = write, 0 = read.
- mem_mc_addr  in  18  Memory-stage halfword address; bit 0 ignored.
- mem_mc_wdata  in  32  write data.
- mc_mem_rdata  out  32  last data word read for the Memory stage.
- mc_mem_valid  out  1  one-cycle pulse; read data ready or write complete.
- mc_ram_addr  out  18  SRAM address.
- mc_ram_wre  out  1  SRAM write enable, active low.
- mc_ram_dout  out  16  SRAM write data.
- mc_ram_doe  out  1  drive enable for the top-level tristate on the SRAM data bus.
- mc_ram_din  in  16  SRAM read data.

## Operation
- Word mapping:
  - Low half at {addr[17:1],1'b0}.
  - High half at {addr[17:1],1'b1}.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Requests are accepted only in IDLE.
  - mem_mc_en has priority over if_mc_en, because the Memory stage holds the older instruction.
- At acceptance, the block latches the requester, direction, word address and wdata. Later input changes are ignored until DONE.
- Accepted read: RD_LO, then RD_HI, then DONE.
- Accepted write: WR_LO, then WR_HI, then DONE.
- Read states:
  - mc_ram_addr is the lo (or hi) address.
  - mc_ram_doe = 0, mc_ram_wre = 1.
  - mc_ram_din is captured at the end of the state into bits [15:0] (lo) or [31:16] (hi) of the latched read word.
- Write states:
  - mc_ram_addr is the lo (or hi) address.
  - mc_ram_dout = wdata[15:0] (lo) or wdata[31:16] (hi).
  - mc_ram_doe = 1, mc_ram_wre = 0 for the whole state.
- DONE:
  - For a read, the requester's data output is loaded from the assembled word.
  - The requester's valid output is high for exactly one cycle; the other valid stays 0.
  - The FSM returns to IDLE unconditionally.
- Data outputs hold their value until the next completion for the same requester.
- A request still high in IDLE after completion starts a new access. Each requester must drop en once it has seen valid.
- Reset values:
  - State IDLE.
  - mc_if_data = mc_mem_rdata = 0, both valids 0.
  - mc_ram_addr = 0, mc_ram_dout = 0, mc_ram_wre = 1, mc_ram_doe = 0.

## Timing
- Request seen high at edge t in IDLE:
  - First RAM state during cycle t+1, second during t+2.
  - DONE during cycle t+3, i.e. valid pulse 3 cycles after acceptance.
  - Next acceptance is possible at edge t+4.
- All RAM outputs are registered; no combinational path from request inputs to RAM pins.
- Simultaneous if_mc_en and mem_mc_en in IDLE: memory is served first, fetch is accepted at the first IDLE after that DONE.
  - Fetch waits 4 extra cycles (fetch valid 7 cycles after both raised).
- Reset mid-access takes effect at the next edge:
  - The access is aborted and no valid pulses.
  - wre returns to 1 and doe to 0 on that edge.
  - A half-written word is left in the RAM.
- addr bit 0 = 1 behaves identically to bit 0 = 0.

## Structure
- Shared package holds:
  - The state enum (6 states, 3-bit encoding).
  - WORD_W = 32.
  - Constants for active-low wre: RAM_WE_ON = 0, RAM_WE_OFF = 1.
- No sub-module. One FSM plus latch registers in a single module. The tristate stays at top level.

## Test plan
- Reset: assert reset for 2 cycles mid-WR_LO -> next cycle wre = 1, doe = 0, state IDLE, no valid pulse, both data outputs 0.
- Fetch read: RAM model holds 0x5678 at 0x00100 and 0x1234 at 0x00101; if_mc_addr = 0x00101 -> lo/hi addresses 0x00100 then 0x00101, mc_if_data = 0x12345678, mc_if_valid pulses exactly 3 cycles after acceptance.
- Memory write: mem_mc_rw = 1, addr 0x3FFFE, wdata 0xDEADBEEF -> 0xBEEF written to 0x3FFFE, 0xDEAD to 0x3FFFF, wre low 2 cycles, mc_mem_valid pulses once.
- Contention: both en raised in the same cycle (fetch addr 0x00000, mem read addr 0x00010) -> mc_mem_valid at t+3, mc_if_valid at t+7, data correct, never both valid in one cycle.
- Hold: after a read completes, change mem_mc_addr with en low -> mc_mem_rdata is unchanged and the RAM pins are idle (wre = 1, doe = 0).
- Back-to-back: en held high for two accesses -> second access accepted immediately after DONE, two valid pulses 4 cycles apart.
